mxv_op_scheduler: RTL and testbench

MXV_OP_SCHEDULER -- requirements
Module: mxv_op_scheduler

---
 rtl/mxv_op_scheduler_pkg.sv | 23 ++
 rtl/mxv_lane_mask_gen.sv | 33 +++
 rtl/mxv_op_scheduler.sv | 145 ++++++++++++++
 tb/tb_mxv_op_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_op_scheduler_pkg.sv
// Shared types and constants for the matrix-vector operation scheduler.
package Definitions_Package;

  localparam int MAX_SIZE = 8;
  localparam int LANES    = 4;

  typedef logic [3:0] ADDR_lenght_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    DRAIN,
    WAIT_TX,
    DONE
  } state_t;

  // A matrix dimension is usable only in 1..MAX_SIZE.
  function automatic logic size_legal(input ADDR_lenght_t n);
    return (n != '0) && (n <= ADDR_lenght_t'(MAX_SIZE));
  endfunction

endpackage

// File: rtl/mxv_lane_mask_gen.sv
// Decodes matrix size and pass number into the set of active processor lanes.
module mxv_lane_mask_gen
  import Definitions_Package::*;
(
  input  ADDR_lenght_t n,
  input  logic         pass,
  output logic [3:0]   lane_mask
);

  ADDR_lenght_t rows;

  // Rows left for this pass: all of N in pass 0, the part beyond lane 4 in pass 1.
  always_comb begin
    rows = '0;
    if (!pass) begin
      rows = n;
    end else if (n > ADDR_lenght_t'(LANES)) begin
      rows = n - ADDR_lenght_t'(LANES);
    end
  end

  always_comb begin
    lane_mask = 4'b0000;
    case (rows)
      4'd0:    lane_mask = 4'b0000;
      4'd1:    lane_mask = 4'b0001;
      4'd2:    lane_mask = 4'b0011;
      4'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase
  end

endmodule

// File: rtl/mxv_op_scheduler.sv
// Sequences RAM reads, lane accumulation and result handoff for one
// matrix-vector operation of size up to 8, split into two 4-lane passes.
module mxv_op_scheduler
  import Definitions_Package::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  ADDR_lenght_t mat_size,
  input  logic         abort,
  input  logic         result_ready,
  output logic         busy,
  output logic [7:0]   rd_en,
  output ADDR_lenght_t rd_addr,
  output logic [3:0]   lane_mask,
  output logic         pass,
  output logic         acc_clr,
  output logic         acc_en,
  output logic         result_valid,
  output logic         done,
  output logic         err
);

  state_t       state_q, state_d;
  ADDR_lenght_t n_q, n_d;
  ADDR_lenght_t col_q, col_d;
  logic         pass_q, pass_d;
  logic         acc_en_q, acc_en_d;
  logic         err_q, err_d;
  logic [3:0]   mask;

  mxv_lane_mask_gen u_lane_mask_gen (
    .n         (n_q),
    .pass      (pass_q),
    .lane_mask (mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      col_q    <= '0;
      pass_q   <= 1'b0;
      acc_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      col_q    <= col_d;
      pass_q   <= pass_d;
      acc_en_q <= acc_en_d;
      err_q    <= err_d;
    end
  end

  // Abort overrides every transition and clears the operation context so the
  // idle outputs return to their reset values.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    col_d    = col_q;
    pass_d   = pass_q;
    err_d    = 1'b0;
    acc_en_d = (state_q == READ);

    if (abort) begin
      state_d  = IDLE;
      n_d      = '0;
      col_d    = '0;
      pass_d   = 1'b0;
      acc_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (size_legal(mat_size)) begin
              n_d     = mat_size;
              col_d   = '0;
              pass_d  = 1'b0;
              state_d = CLEAR;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CLEAR: begin
          state_d = READ;
        end
        READ: begin
          // Compare with >= so a stray column value still ends the pass.
          if (col_q >= n_q - ADDR_lenght_t'(1)) begin
            col_d   = '0;
            state_d = DRAIN;
          end else begin
            col_d = col_q + ADDR_lenght_t'(1);
          end
        end
        DRAIN: begin
          state_d = WAIT_TX;
        end
        WAIT_TX: begin
          if (result_ready) begin
            if (!pass_q && (n_q > ADDR_lenght_t'(LANES))) begin
              pass_d  = 1'b1;
              state_d = CLEAR;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          n_d     = '0;
          col_d   = '0;
          pass_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          n_d     = '0;
          col_d   = '0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // Moore output decode; the bank half is chosen by the current pass.
  always_comb begin
    busy         = (state_q != IDLE);
    rd_en        = 8'h00;
    rd_addr      = '0;
    lane_mask    = mask;
    pass         = pass_q;
    acc_clr      = (state_q == CLEAR);
    acc_en       = acc_en_q;
    result_valid = (state_q == WAIT_TX);
    done         = (state_q == DONE);
    err          = err_q;
    if (state_q == READ) begin
      rd_addr = col_q;
      rd_en   = pass_q ? {mask, 4'b0000} : {4'b0000, mask};
    end
  end

endmodule

// File: tb/tb_mxv_op_scheduler.sv
// Directed self-checking bench for mxv_op_scheduler with hand-computed vectors.
module tb_mxv_op_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] matSize;
  logic       abort;
  logic       resultReady;
  logic       busy;
  logic [7:0] rdEn;
  logic [3:0] rdAddr;
  logic [3:0] laneMask;
  logic       passOut;
  logic       accClr;
  logic       accEn;
  logic       resultValid;
  logic       done;
  logic       err;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [22:0] allOuts;
  assign allOuts = {busy, rdEn, rdAddr, laneMask, passOut, accClr, accEn,
                    resultValid, done, err};

  mxv_op_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mat_size     (matSize),
    .abort        (abort),
    .result_ready (resultReady),
    .busy         (busy),
    .rd_en        (rdEn),
    .rd_addr      (rdAddr),
    .lane_mask    (laneMask),
    .pass         (passOut),
    .acc_clr      (accClr),
    .acc_en       (accEn),
    .result_valid (resultValid),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startV, input logic [3:0] sizeV,
                               input logic readyV, input logic abortV);
    start       = startV;
    matSize     = sizeV;
    resultReady = readyV;
    abort       = abortV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one full operation starting this cycle; rdPass1 == 0 means single pass.
  task automatic runOp(input int n, input logic [7:0] rdPass0,
                       input logic [7:0] rdPass1, input int readyDelay,
                       input bit holdReady);
    int         passes;
    int         handshakes;
    logic [7:0] rdExp;
    logic [3:0] maskExp;
    passes     = (rdPass1 != 8'h00) ? 2 : 1;
    handshakes = 0;
    applyStimulus(1'b1, 4'(n), holdReady, 1'b0);
    tick();
    applyStimulus(1'b0, 4'(n), holdReady, 1'b0);
    for (int p = 0; p < passes; p++) begin
      rdExp   = (p == 0) ? rdPass0 : rdPass1;
      maskExp = (p == 0) ? rdExp[3:0] : rdExp[7:4];
      checkOutput($sformatf("n%0d_p%0d_clr", n, p), 32'(accClr), 32'd1);
      checkOutput($sformatf("n%0d_p%0d_clr_rden", n, p), 32'(rdEn), 32'd0);
      checkOutput($sformatf("n%0d_p%0d_clr_busy", n, p), 32'(busy), 32'd1);
      tick();
      for (int c = 0; c < n; c++) begin
        checkOutput($sformatf("n%0d_p%0d_c%0d_rden", n, p, c), 32'(rdEn), 32'(rdExp));
        checkOutput($sformatf("n%0d_p%0d_c%0d_addr", n, p, c), 32'(rdAddr), 32'(c));
        checkOutput($sformatf("n%0d_p%0d_c%0d_accen", n, p, c), 32'(accEn), 32'(c != 0));
        checkOutput($sformatf("n%0d_p%0d_c%0d_mask", n, p, c), 32'(laneMask), 32'(maskExp));
        checkOutput($sformatf("n%0d_p%0d_c%0d_pass", n, p, c), 32'(passOut), 32'(p));
        checkOutput($sformatf("n%0d_p%0d_c%0d_clr", n, p, c), 32'(accClr), 32'd0);
        tick();
      end
      checkOutput($sformatf("n%0d_p%0d_drain_rden", n, p), 32'(rdEn), 32'd0);
      checkOutput($sformatf("n%0d_p%0d_drain_accen", n, p), 32'(accEn), 32'd1);
      checkOutput($sformatf("n%0d_p%0d_drain_rv", n, p), 32'(resultValid), 32'd0);
      tick();
      for (int d = 0; d < readyDelay; d++) begin
        checkOutput($sformatf("n%0d_p%0d_wait%0d_rv", n, p, d), 32'(resultValid), 32'd1);
        checkOutput($sformatf("n%0d_p%0d_wait%0d_rden", n, p, d), 32'(rdEn), 32'd0);
        checkOutput($sformatf("n%0d_p%0d_wait%0d_done", n, p, d), 32'(done), 32'd0);
        tick();
      end
      checkOutput($sformatf("n%0d_p%0d_tx_rv", n, p), 32'(resultValid), 32'd1);
      checkOutput($sformatf("n%0d_p%0d_tx_rden", n, p), 32'(rdEn), 32'd0);
      checkOutput($sformatf("n%0d_p%0d_tx_accen", n, p), 32'(accEn), 32'd0);
      if (resultValid) handshakes++;
      applyStimulus(1'b0, 4'(n), 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 4'(n), holdReady, 1'b0);
    end
    checkOutput($sformatf("n%0d_done", n), 32'(done), 32'd1);
    checkOutput($sformatf("n%0d_done_rv", n), 32'(resultValid), 32'd0);
    tick();
    checkOutput($sformatf("n%0d_idle_outs", n), 32'(allOuts), 32'd0);
    checkOutput($sformatf("n%0d_handshakes", n), 32'(handshakes), 32'(passes));
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_outs", 32'(allOuts), 32'd0);
    tick();
    tick();
    checkOutput("reset_hold_outs", 32'(allOuts), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("idle_outs", 32'(allOuts), 32'd0);

    runOp(3, 8'h07, 8'h00, 0, 1'b1);
    runOp(8, 8'h0F, 8'hF0, 0, 1'b0);
    runOp(6, 8'h0F, 8'h30, 0, 1'b0);

    // Illegal sizes: err pulses once each, nothing else moves
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("size0_err", 32'(err), 32'd1);
    checkOutput("size0_busy", 32'(busy), 32'd0);
    checkOutput("size0_rden", 32'(rdEn), 32'd0);
    tick();
    checkOutput("size0_err_clear", 32'(err), 32'd0);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("size9_err", 32'(err), 32'd1);
    checkOutput("size9_busy", 32'(busy), 32'd0);
    checkOutput("size9_rden", 32'(rdEn), 32'd0);
    tick();
    checkOutput("size9_idle_outs", 32'(allOuts), 32'd0);

    runOp(2, 8'h03, 8'h00, 5, 1'b0);

    // Abort at READ col 2 with a stray start during CLEAR
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
    checkOutput("abort_clr", 32'(accClr), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("abort_c0_rden", 32'(rdEn), 32'h0F);
    tick();
    checkOutput("abort_c1_addr", 32'(rdAddr), 32'd1);
    tick();
    checkOutput("abort_c2_addr", 32'(rdAddr), 32'd2);
    checkOutput("abort_c2_mask", 32'(laneMask), 32'hF);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("abort_outs", 32'(allOuts), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort_after%0d_outs", i), 32'(allOuts), 32'd0);
    end

    // Abort wins over a simultaneous handshake
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("abort_tx_rv", 32'(resultValid), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("abort_tx_outs", 32'(allOuts), 32'd0);
    tick();
    checkOutput("abort_tx_nodone", 32'(done), 32'd0);

    // Asynchronous reset mid-READ, then a normal N=4 run
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_c1_addr", 32'(rdAddr), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_outs", 32'(allOuts), 32'd0);
    tick();
    checkOutput("rst_hold_outs", 32'(allOuts), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rst_release_outs", 32'(allOuts), 32'd0);
    tick();
    checkOutput("rst_nodone", 32'(done), 32'd0);
    runOp(4, 8'h0F, 8'h00, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
